// File: rtl/prim_ram_2p_fifo_ctrl.sv
// FIFO controller in front of a simple dual-port SRAM (port A write, port B read).
// Port B data returns one cycle after the request. A 2-entry output buffer hides that
// latency so the FIFO can accept one push and deliver one pop every cycle.
module prim_ram_2p_fifo_ctrl #(
    parameter int unsigned Width = 32,
    parameter int unsigned Depth = 128,
    localparam int unsigned Aw = $clog2(Depth)
) (
    input  logic             clk_i,
    input  logic             rst_i,

    input  logic             wvalid_i,
    output logic             wready_o,
    input  logic [Width-1:0] wdata_i,

    output logic             rvalid_o,
    input  logic             rready_i,
    output logic [Width-1:0] rdata_o,

    output logic [Aw+1:0]    depth_o,
    output logic             full_o,
    output logic             empty_o,

    output logic             ram_a_req_o,
    output logic             ram_a_write_o,
    output logic [Aw-1:0]    ram_a_addr_o,
    output logic [Width-1:0] ram_a_wdata_o,
    output logic [Width-1:0] ram_a_wmask_o,

    output logic             ram_b_req_o,
    output logic             ram_b_write_o,
    output logic [Aw-1:0]    ram_b_addr_o,
    input  logic [Width-1:0] ram_b_rdata_i
);

    logic [Aw:0]             wptr_q, rptr_q;
    logic [Aw:0]             ram_cnt;
    logic                    inflight_q;
    logic [1:0]              ob_cnt_q, ob_cnt_d;
    logic [1:0][Width-1:0]   ob_q, ob_d;
    // Low during reset and for the first cycle after it. This keeps the FIFO closed
    // for that first cycle.
    logic                    init_q;
    logic                    active;
    logic                    ram_full;
    logic                    push, pop, rd_issue;
    logic [2:0]              ob_occ;

    assign active   = init_q & ~rst_i;
    assign ram_cnt  = wptr_q - rptr_q;
    assign ram_full = (ram_cnt == (Aw+1)'(Depth));

    assign wready_o = active & ~ram_full;
    assign push     = wvalid_i & wready_o;
    assign rvalid_o = active & (ob_cnt_q != 2'd0);
    assign pop      = rvalid_o & rready_i;

    // Buffer slots committed after this cycle: stored entries, plus the landing one,
    // minus the one being popped.
    assign ob_occ   = {1'b0, ob_cnt_q} + {2'b0, inflight_q} - {2'b0, pop};
    assign rd_issue = active & (ram_cnt != '0) & (ob_occ < 3'd2);

    assign ram_a_req_o   = push;
    assign ram_a_write_o = 1'b1;
    assign ram_a_addr_o  = wptr_q[Aw-1:0];
    assign ram_a_wdata_o = wdata_i;
    assign ram_a_wmask_o = '1;

    assign ram_b_req_o   = rd_issue;
    assign ram_b_write_o = 1'b0;
    assign ram_b_addr_o  = rptr_q[Aw-1:0];

    assign rdata_o = active ? ob_q[0] : '0;
    assign depth_o = active ? ({1'b0, ram_cnt} + (Aw+2)'(inflight_q) + (Aw+2)'(ob_cnt_q)) : '0;
    assign full_o  = active & ram_full;
    assign empty_o = (depth_o == '0);

    // Output buffer next state: shift the head out on pop, then land at the new tail.
    always_comb begin
        ob_d     = ob_q;
        ob_cnt_d = ob_cnt_q;
        if (pop) begin
            ob_d[0]  = ob_q[1];
            ob_cnt_d = ob_cnt_q - 2'd1;
        end
        if (inflight_q) begin
            ob_d[ob_cnt_d[0]] = ram_b_rdata_i;
            ob_cnt_d          = ob_cnt_d + 2'd1;
        end
    end

    // Pointers, in-flight flag and output buffer registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            init_q     <= 1'b0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            inflight_q <= 1'b0;
            ob_cnt_q   <= 2'd0;
            ob_q       <= '0;
        end else begin
            init_q     <= 1'b1;
            inflight_q <= rd_issue;
            ob_cnt_q   <= ob_cnt_d;
            ob_q       <= ob_d;
            if (push) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (rd_issue) begin
                rptr_q <= rptr_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_prim_ram_2p_fifo_ctrl.sv
// Directed bench for prim_ram_2p_fifo_ctrl with a behavioural 1-cycle-latency SRAM.
module tb_prim_ram_2p_fifo_ctrl;

    localparam int unsigned Width = 32;
    localparam int unsigned Depth = 128;
    localparam int unsigned Aw    = $clog2(Depth);

    logic             clk;
    logic             rst;
    logic             wvalid, wready, rvalid, rready;
    logic [Width-1:0] wdata, rdata;
    logic [Aw+1:0]    depth;
    logic             full, empty;
    logic             ram_a_req, ram_a_write, ram_b_req, ram_b_write;
    logic [Aw-1:0]    ram_a_addr, ram_b_addr;
    logic [Width-1:0] ram_a_wdata, ram_a_wmask, ram_b_rdata;

    logic [Width-1:0] mem [Depth];

    int checks = 0;
    int errors = 0;

    prim_ram_2p_fifo_ctrl #(.Width(Width), .Depth(Depth)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .wvalid_i     (wvalid),
        .wready_o     (wready),
        .wdata_i      (wdata),
        .rvalid_o     (rvalid),
        .rready_i     (rready),
        .rdata_o      (rdata),
        .depth_o      (depth),
        .full_o       (full),
        .empty_o      (empty),
        .ram_a_req_o  (ram_a_req),
        .ram_a_write_o(ram_a_write),
        .ram_a_addr_o (ram_a_addr),
        .ram_a_wdata_o(ram_a_wdata),
        .ram_a_wmask_o(ram_a_wmask),
        .ram_b_req_o  (ram_b_req),
        .ram_b_write_o(ram_b_write),
        .ram_b_addr_o (ram_b_addr),
        .ram_b_rdata_i(ram_b_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial ram_b_rdata = '0;
    // SRAM model: write on port A, registered read on port B.
    always @(posedge clk) begin
        if (ram_a_req && ram_a_write) mem[ram_a_addr] <= ram_a_wdata & ram_a_wmask;
        if (ram_b_req && !ram_b_write) ram_b_rdata <= mem[ram_b_addr];
    end

    // Inputs change just after the rising edge. Outputs are sampled on the falling edge.
    task automatic drive_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; wvalid = 1'b0; rready = 1'b0; wdata = '0;
        repeat (3) drive_edge();
        @(negedge clk);
        checks++;
        if (wready !== 1'b0 || rvalid !== 1'b0 || ram_a_req !== 1'b0 || ram_b_req !== 1'b0) begin
            errors++;
            $display("FAIL rst_ctrl: wready=%b rvalid=%b a_req=%b b_req=%b, want all 0",
                     wready, rvalid, ram_a_req, ram_b_req);
        end
        checks++;
        if (depth !== '0 || empty !== 1'b1 || full !== 1'b0 || rdata !== '0) begin
            errors++;
            $display("FAIL rst_status: depth=%0d empty=%b full=%b rdata=%h, want 0 1 0 0",
                     depth, empty, full, rdata);
        end
        checks++;
        if (ram_a_write !== 1'b1 || ram_b_write !== 1'b0 || ram_a_wmask !== '1) begin
            errors++;
            $display("FAIL ram_consts: a_write=%b b_write=%b wmask=%h", ram_a_write,
                     ram_b_write, ram_a_wmask);
        end
        drive_edge();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (wready !== 1'b0 || ram_b_req !== 1'b0) begin
            errors++;
            $display("FAIL rst_release_cycle: wready=%b b_req=%b, want 0 0", wready, ram_b_req);
        end
        drive_edge();
        @(negedge clk);
        checks++;
        if (wready !== 1'b1 || empty !== 1'b1) begin
            errors++;
            $display("FAIL rst_ready: wready=%b empty=%b, want 1 1", wready, empty);
        end
    endtask

    task automatic test_single();
        drive_edge();
        wvalid = 1'b1; wdata = 32'hA5A5_0001;
        @(negedge clk);
        checks++;
        if (wready !== 1'b1 || ram_a_req !== 1'b1) begin
            errors++;
            $display("FAIL single_push: wready=%b a_req=%b, want 1 1", wready, ram_a_req);
        end
        drive_edge();
        wvalid = 1'b0;
        @(negedge clk);
        checks++;
        if (ram_b_req !== 1'b1 || rvalid !== 1'b0 || depth !== 9'd1) begin
            errors++;
            $display("FAIL single_issue: b_req=%b rvalid=%b depth=%0d, want 1 0 1",
                     ram_b_req, rvalid, depth);
        end
        drive_edge();
        @(negedge clk);
        checks++;
        if (rvalid !== 1'b0 || depth !== 9'd1) begin
            errors++;
            $display("FAIL single_land: rvalid=%b depth=%0d, want 0 1", rvalid, depth);
        end
        drive_edge();
        rready = 1'b1;
        @(negedge clk);
        checks++;
        if (rvalid !== 1'b1 || rdata !== 32'hA5A5_0001) begin
            errors++;
            $display("FAIL single_valid: rvalid=%b rdata=%h, want 1 a5a50001", rvalid, rdata);
        end
        drive_edge();
        rready = 1'b0;
        @(negedge clk);
        checks++;
        if (empty !== 1'b1 || depth !== '0 || rvalid !== 1'b0) begin
            errors++;
            $display("FAIL single_empty: empty=%b depth=%0d rvalid=%b, want 1 0 0",
                     empty, depth, rvalid);
        end
    endtask

    task automatic test_fill_drain();
        int idx = 0;
        int guard = 0;
        int exp = 0;
        int ncyc = 0;
        rready = 1'b0;
        while (idx < Depth + 2 && guard < 1000) begin
            drive_edge();
            wvalid = 1'b1; wdata = idx;
            @(negedge clk);
            if (wready) idx++;
            guard++;
        end
        drive_edge();
        wvalid = 1'b0;
        checks++;
        if (idx != Depth + 2) begin
            errors++;
            $display("FAIL fill_count: pushed=%0d, want %0d", idx, Depth + 2);
        end
        repeat (4) drive_edge();
        @(negedge clk);
        checks++;
        if (depth !== 9'(Depth + 2) || full !== 1'b1 || wready !== 1'b0 || rvalid !== 1'b1) begin
            errors++;
            $display("FAIL fill_full: depth=%0d full=%b wready=%b rvalid=%b, want %0d 1 0 1",
                     depth, full, wready, rvalid, Depth + 2);
        end
        guard = 0;
        while (exp < Depth + 2 && guard < 1000) begin
            drive_edge();
            rready = 1'b1;
            @(negedge clk);
            if (ncyc == 0) begin
                checks++;
                if (ram_b_req !== 1'b1) begin
                    errors++;
                    $display("FAIL drain_refill_issue: b_req=%b, want 1", ram_b_req);
                end
            end else if (ncyc == 1) begin
                checks++;
                if (wready !== 1'b1 || full !== 1'b0) begin
                    errors++;
                    $display("FAIL drain_wready_back: wready=%b full=%b, want 1 0", wready, full);
                end
            end
            if (rvalid) begin
                checks++;
                if (rdata !== 32'(exp)) begin
                    errors++;
                    $display("FAIL drain_data: got %h, want %h", rdata, 32'(exp));
                end
                exp++;
            end
            ncyc++;
            guard++;
        end
        drive_edge();
        rready = 1'b0;
        @(negedge clk);
        checks++;
        if (exp != Depth + 2 || empty !== 1'b1) begin
            errors++;
            $display("FAIL drain_done: popped=%0d empty=%b, want %0d 1", exp, empty, Depth + 2);
        end
    endtask

    task automatic test_back_to_back();
        int n = 3 * Depth;
        int sent = 0;
        int got = 0;
        int bubbles = 0;
        int stalls = 0;
        int guard = 0;
        bit started = 1'b0;
        while (got < n && guard < n + 50) begin
            drive_edge();
            wvalid = (sent < n); wdata = 32'h5000_0000 + sent; rready = 1'b1;
            @(negedge clk);
            if (wvalid && wready) sent++;
            else if (wvalid) stalls++;
            if (rvalid) begin
                checks++;
                if (rdata !== 32'h5000_0000 + got) begin
                    errors++;
                    $display("FAIL stream_data: got %h, want %h", rdata, 32'h5000_0000 + got);
                end
                got++;
                started = 1'b1;
            end else if (started) begin
                bubbles++;
            end
            guard++;
        end
        drive_edge();
        wvalid = 1'b0; rready = 1'b0;
        checks++;
        if (got != n || bubbles != 0 || stalls != 0) begin
            errors++;
            $display("FAIL stream_rate: popped=%0d bubbles=%0d stalls=%0d, want %0d 0 0",
                     got, bubbles, stalls, n);
        end
    endtask

    task automatic test_random();
        logic [Width-1:0] sb[$];
        logic [Width-1:0] want;
        int model_depth = 0;
        int total = 10000 + Depth + 50;
        for (int c = 0; c < total; c++) begin
            drive_edge();
            if (c < 4000) begin
                wvalid = ($urandom_range(0, 3) != 0); rready = ($urandom_range(0, 3) == 0);
            end else if (c < 8000) begin
                wvalid = ($urandom_range(0, 3) == 0); rready = ($urandom_range(0, 3) != 0);
            end else if (c < 10000) begin
                wvalid = ($urandom_range(0, 1) == 0); rready = ($urandom_range(0, 1) == 0);
            end else begin
                wvalid = 1'b0; rready = 1'b1;
            end
            wdata = $urandom;
            @(negedge clk);
            checks++;
            if (depth !== 9'(model_depth) || empty !== (model_depth == 0)) begin
                errors++;
                $display("FAIL rand_depth: cycle %0d depth=%0d empty=%b, want %0d", c, depth,
                         empty, model_depth);
            end
            if (wvalid && wready) begin
                sb.push_back(wdata);
                model_depth++;
            end
            if (rvalid && rready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL rand_extra_pop: cycle %0d rdata=%h, want no data", c, rdata);
                end else begin
                    want = sb.pop_front();
                    model_depth--;
                    if (rdata !== want) begin
                        errors++;
                        $display("FAIL rand_data: cycle %0d got %h, want %h", c, rdata, want);
                    end
                end
            end
        end
        drive_edge();
        wvalid = 1'b0; rready = 1'b0;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL rand_leftover: %0d entries never popped, want 0", sb.size());
        end
    endtask

    task automatic test_reset_mid();
        int guard = 0;
        rready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            drive_edge();
            wvalid = 1'b1; wdata = 32'hBEEF_0000 + i;
        end
        drive_edge();
        wvalid = 1'b0;
        repeat (4) drive_edge();
        rready = 1'b1;
        @(negedge clk);
        checks++;
        if (ram_b_req !== 1'b1 || depth !== 9'd6) begin
            errors++;
            $display("FAIL mid_setup: b_req=%b depth=%0d, want 1 6", ram_b_req, depth);
        end
        drive_edge();
        rready = 1'b0; rst = 1'b1;
        @(negedge clk);
        checks++;
        if (rvalid !== 1'b0 || depth !== '0 || wready !== 1'b0) begin
            errors++;
            $display("FAIL mid_in_reset: rvalid=%b depth=%0d wready=%b, want 0 0 0",
                     rvalid, depth, wready);
        end
        drive_edge();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (rvalid !== 1'b0 || depth !== '0 || wready !== 1'b0) begin
            errors++;
            $display("FAIL mid_after_reset: rvalid=%b depth=%0d wready=%b, want 0 0 0",
                     rvalid, depth, wready);
        end
        drive_edge();
        wvalid = 1'b1; wdata = 32'h0000_1234;
        @(negedge clk);
        checks++;
        if (wready !== 1'b1) begin
            errors++;
            $display("FAIL mid_push_ready: wready=%b, want 1", wready);
        end
        drive_edge();
        wvalid = 1'b0; rready = 1'b1;
        @(negedge clk);
        while (!rvalid && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (rvalid !== 1'b1 || rdata !== 32'h0000_1234) begin
            errors++;
            $display("FAIL mid_first_pop: rvalid=%b rdata=%h, want 1 00001234", rvalid, rdata);
        end
        drive_edge();
        rready = 1'b0;
        @(negedge clk);
        checks++;
        if (empty !== 1'b1) begin
            errors++;
            $display("FAIL mid_empty: empty=%b depth=%0d, want 1 0", empty, depth);
        end
    endtask

    task automatic test_land_pop();
        rready = 1'b0;
        drive_edge();
        wvalid = 1'b1; wdata = 32'hAAAA_0001;
        drive_edge();
        wdata = 32'hAAAA_0002;
        drive_edge();
        wvalid = 1'b0;
        drive_edge();
        wvalid = 1'b1; wdata = 32'hAAAA_0003; rready = 1'b1;
        @(negedge clk);
        checks++;
        if (rvalid !== 1'b1 || rdata !== 32'hAAAA_0001 || depth !== 9'd2 || wready !== 1'b1) begin
            errors++;
            $display("FAIL lp_before: rvalid=%b rdata=%h depth=%0d wready=%b, want 1 aaaa0001 2 1",
                     rvalid, rdata, depth, wready);
        end
        drive_edge();
        wvalid = 1'b0; rready = 1'b0;
        @(negedge clk);
        checks++;
        if (rvalid !== 1'b1 || rdata !== 32'hAAAA_0002 || depth !== 9'd2 || ram_b_req !== 1'b1) begin
            errors++;
            $display("FAIL lp_after: rvalid=%b rdata=%h depth=%0d b_req=%b, want 1 aaaa0002 2 1",
                     rvalid, rdata, depth, ram_b_req);
        end
        drive_edge();
        rready = 1'b1;
        @(negedge clk);
        checks++;
        if (rvalid !== 1'b1 || rdata !== 32'hAAAA_0002) begin
            errors++;
            $display("FAIL lp_pop_b: rvalid=%b rdata=%h, want 1 aaaa0002", rvalid, rdata);
        end
        drive_edge();
        @(negedge clk);
        checks++;
        if (rvalid !== 1'b1 || rdata !== 32'hAAAA_0003 || depth !== 9'd1) begin
            errors++;
            $display("FAIL lp_pop_c: rvalid=%b rdata=%h depth=%0d, want 1 aaaa0003 1",
                     rvalid, rdata, depth);
        end
        drive_edge();
        rready = 1'b0;
        @(negedge clk);
        checks++;
        if (empty !== 1'b1 || rvalid !== 1'b0) begin
            errors++;
            $display("FAIL lp_empty: empty=%b rvalid=%b, want 1 0", empty, rvalid);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_fill_drain();
        test_back_to_back();
        test_random();
        test_reset_mid();
        test_land_pop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
